// File: rtl/seven_seg_pkg.sv
// Shared constants for the scrolling seven-segment display driver:
// character code width, named character codes and the all-off segment pattern.
package seven_seg_pkg;

    localparam int CODE_W = 5;

    localparam logic [6:0] SEG_OFF = 7'h7F;

    localparam logic [CODE_W-1:0] CH_H     = 5'h10;
    localparam logic [CODE_W-1:0] CH_L     = 5'h11;
    localparam logic [CODE_W-1:0] CH_P     = 5'h12;
    localparam logic [CODE_W-1:0] CH_U     = 5'h13;
    localparam logic [CODE_W-1:0] CH_R     = 5'h14;
    localparam logic [CODE_W-1:0] CH_N     = 5'h15;
    localparam logic [CODE_W-1:0] CH_O     = 5'h16;
    localparam logic [CODE_W-1:0] CH_T     = 5'h17;
    localparam logic [CODE_W-1:0] CH_Y     = 5'h18;
    localparam logic [CODE_W-1:0] CH_DASH  = 5'h19;
    localparam logic [CODE_W-1:0] CH_UNDER = 5'h1A;
    localparam logic [CODE_W-1:0] CH_J     = 5'h1B;
    localparam logic [CODE_W-1:0] CH_I     = 5'h1C;
    localparam logic [CODE_W-1:0] CH_C     = 5'h1D;
    localparam logic [CODE_W-1:0] CH_DEG   = 5'h1E;
    localparam logic [CODE_W-1:0] CH_BLANK = 5'h1F;

endpackage

// File: rtl/seven_seg_font.sv
// Character font: 5-bit character code to active-low {g,f,e,d,c,b,a} segments.
// Purely combinational; blank (and anything unmapped) drives every segment off.
module seven_seg_font
    import seven_seg_pkg::*;
(
    input  logic [CODE_W-1:0] code,
    output logic [6:0]        seg_n
);

    logic [6:0] lit;

    // Look up which segments are lit for the code (active-high), inverted below for the common-anode pins
    always_comb begin
        lit = 7'h00;
        case (code)
            5'h00:    lit = 7'h3F;
            5'h01:    lit = 7'h06;
            5'h02:    lit = 7'h5B;
            5'h03:    lit = 7'h4F;
            5'h04:    lit = 7'h66;
            5'h05:    lit = 7'h6D;
            5'h06:    lit = 7'h7D;
            5'h07:    lit = 7'h07;
            5'h08:    lit = 7'h7F;
            5'h09:    lit = 7'h6F;
            5'h0A:    lit = 7'h77;
            5'h0B:    lit = 7'h7C;
            5'h0C:    lit = 7'h39;
            5'h0D:    lit = 7'h5E;
            5'h0E:    lit = 7'h79;
            5'h0F:    lit = 7'h71;
            CH_H:     lit = 7'h76;
            CH_L:     lit = 7'h38;
            CH_P:     lit = 7'h73;
            CH_U:     lit = 7'h3E;
            CH_R:     lit = 7'h50;
            CH_N:     lit = 7'h54;
            CH_O:     lit = 7'h5C;
            CH_T:     lit = 7'h78;
            CH_Y:     lit = 7'h6E;
            CH_DASH:  lit = 7'h40;
            CH_UNDER: lit = 7'h08;
            CH_J:     lit = 7'h1E;
            CH_I:     lit = 7'h10;
            CH_C:     lit = 7'h58;
            CH_DEG:   lit = 7'h63;
            default:  lit = 7'h00;
        endcase
    end

    assign seg_n = ~lit;

endmodule

// File: rtl/seven_seg_scroll_xn.sv
// Multiplexed common-anode seven-segment driver with a character buffer that
// scrolls right-to-left when the message is longer than the display.
// Optional decimal-point support is enabled by defining SEVEN_SEG_DP_EN.
module seven_seg_scroll_xn
    import seven_seg_pkg::*;
#(
    parameter int NUM_DIGITS  = 8,
    parameter int DEPTH       = 32,
    parameter int REFRESH_DIV = 100000,
    parameter int SCROLL_DIV  = 50000000
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [CODE_W-1:0]            char_code,
    input  logic                         char_valid,
    output logic                         char_ready,
    input  logic                         clear,
    input  logic                         scroll_en,
    output logic [$clog2(DEPTH+1)-1:0]   msg_len,
`ifdef SEVEN_SEG_DP_EN
    input  logic [NUM_DIGITS-1:0]        dp_mask,
    output logic                         dp,
`endif
    output logic [6:0]                   segments,
    output logic [NUM_DIGITS-1:0]        digits
);

    localparam int LEN_W  = $clog2(DEPTH + 1);
    localparam int ADDR_W = $clog2(DEPTH);
    localparam int IDX_W  = $clog2(NUM_DIGITS);
    localparam int REF_W  = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int SCR_W  = (SCROLL_DIV > 1) ? $clog2(SCROLL_DIV) : 1;

    logic [CODE_W-1:0] msg_buf [DEPTH];
    logic [REF_W-1:0]  refresh_cnt;
    logic [IDX_W-1:0]  scan_idx;
    logic [SCR_W-1:0]  scroll_cnt;
    logic [LEN_W-1:0]  offset;

    logic              write_en;
    logic              refresh_wrap;
    logic              scroll_active;
    logic              scroll_wrap;

    logic [IDX_W-1:0]  pos;
    logic [LEN_W-1:0]  pos_ext;
    logic [LEN_W:0]    rd_sum;
    logic [ADDR_W-1:0] rd_addr;
    logic [CODE_W-1:0] window_code;
    logic [6:0]        font_seg;

    assign char_ready    = !reset && !clear && (msg_len < LEN_W'(DEPTH));
    assign write_en      = char_valid && char_ready;
    assign refresh_wrap  = (refresh_cnt == REF_W'(REFRESH_DIV - 1));
    assign scroll_active = scroll_en && (msg_len > LEN_W'(NUM_DIGITS));
    assign scroll_wrap   = (scroll_cnt == SCR_W'(SCROLL_DIV - 1));

    // Refresh prescaler and digit scan index; the index steps once per prescaler wrap
    always_ff @(posedge clk) begin
        if (reset) begin
            refresh_cnt <= '0;
            scan_idx    <= '0;
        end else if (refresh_wrap) begin
            refresh_cnt <= '0;
            scan_idx    <= (scan_idx == IDX_W'(NUM_DIGITS - 1)) ? '0 : scan_idx + IDX_W'(1);
        end else begin
            refresh_cnt <= refresh_cnt + REF_W'(1);
        end
    end

    // Message length: clear wins over a simultaneous write
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            msg_len <= '0;
        end else if (write_en) begin
            msg_len <= msg_len + LEN_W'(1);
        end
    end

    // Buffer storage; contents survive reset and clear but become unreachable once msg_len is zero
    always_ff @(posedge clk) begin
        if (write_en) begin
            msg_buf[ADDR_W'(msg_len)] <= char_code;
        end
    end

    // Scroll prescaler and circular window offset; both parked at zero whenever scrolling is idle
    always_ff @(posedge clk) begin
        if (reset || clear || !scroll_active) begin
            scroll_cnt <= '0;
            offset     <= '0;
        end else if (scroll_wrap) begin
            scroll_cnt <= '0;
            offset     <= (offset == msg_len - LEN_W'(1)) ? '0 : offset + LEN_W'(1);
        end else begin
            scroll_cnt <= scroll_cnt + SCR_W'(1);
        end
    end

    // Pick the character for the scanned position; offset and position are both below msg_len so one subtract folds the sum
    always_comb begin
        pos         = IDX_W'(NUM_DIGITS - 1) - scan_idx;
        pos_ext     = LEN_W'(pos);
        rd_sum      = {1'b0, offset} + {1'b0, pos_ext};
        rd_addr     = (rd_sum >= {1'b0, msg_len}) ? ADDR_W'(rd_sum - {1'b0, msg_len})
                                                  : ADDR_W'(rd_sum);
        window_code = CH_BLANK;
        if (msg_len == '0) begin
            window_code = CH_BLANK;
        end else if ((msg_len <= LEN_W'(NUM_DIGITS)) && (pos_ext >= msg_len)) begin
            window_code = CH_BLANK;
        end else begin
            window_code = msg_buf[rd_addr];
        end
    end

    seven_seg_font u_font (
        .code  (window_code),
        .seg_n (font_seg)
    );

    // Register anode select and segments together so a digit never shows its neighbour's pattern
    always_ff @(posedge clk) begin
        if (reset) begin
            segments <= SEG_OFF;
            digits   <= '1;
`ifdef SEVEN_SEG_DP_EN
            dp       <= 1'b1;
`endif
        end else begin
            segments <= font_seg;
            digits   <= ~(NUM_DIGITS'(1) << scan_idx);
`ifdef SEVEN_SEG_DP_EN
            dp       <= ~dp_mask[scan_idx];
`endif
        end
    end

endmodule
